// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory: core has priority,
// debug gets a bounded-wait guarantee and optional locked bursts.
module dmem_port_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned LOCK_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {ARB, DBG_FORCE, DBG_LOCK} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_DBG} owner_t;

  state_t              state, state_n;
  owner_t              rsp_owner, owner_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [LOCK_W-1:0]   lock_cnt, lock_n;
  logic                core_gnt;
  logic                dbg_gnt_c;
  logic [DATA_W-1:0]   core_rdata_q, dbg_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ARB;
      wait_cnt     <= '0;
      lock_cnt     <= '0;
      rsp_owner    <= OWN_NONE;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      lock_cnt  <= lock_n;
      rsp_owner <= owner_n;
      if (rsp_owner == OWN_CORE) core_rdata_q <= mem_rd_data;
      if (rsp_owner == OWN_DBG)  dbg_rdata_q  <= mem_rd_data;
    end
  end

  always_comb begin
    state_n   = state;
    wait_n    = '0;
    lock_n    = '0;
    core_gnt  = 1'b0;
    dbg_gnt_c = 1'b0;
    case (state)
      ARB: begin
        if (core_req)     core_gnt  = 1'b1;
        else if (dbg_req) dbg_gnt_c = 1'b1;
        if (dbg_req && !dbg_gnt_c) begin
          wait_n = (wait_cnt == WAIT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
          if (wait_n == WAIT_W'(MAX_WAIT)) state_n = DBG_FORCE;
        end
        if (dbg_gnt_c && dbg_lock) begin
          state_n = DBG_LOCK;
          lock_n  = LOCK_W'(1);
        end
      end
      DBG_FORCE: begin
        state_n = ARB;
        if (dbg_req) begin
          dbg_gnt_c = 1'b1;
          if (dbg_lock) begin
            state_n = DBG_LOCK;
            lock_n  = LOCK_W'(1);
          end
        end
      end
      DBG_LOCK: begin
        // Any exit lands in ARB, where core priority grants it next cycle.
        state_n = ARB;
        if (dbg_req && dbg_lock) begin
          dbg_gnt_c = 1'b1;
          lock_n    = lock_cnt + 1'b1;
          if (lock_n != LOCK_W'(LOCK_MAX)) state_n = DBG_LOCK;
        end
      end
      default: state_n = ARB;
    endcase
    if (reset) begin
      core_gnt  = 1'b0;
      dbg_gnt_c = 1'b0;
    end
  end

  always_comb begin
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    owner_n     = OWN_NONE;
    if (core_gnt) begin
      mem_wr      = core_we;
      mem_rd      = ~core_we;
      mem_addr    = core_addr;
      mem_wr_data = core_wdata;
      if (!core_we) owner_n = OWN_CORE;
    end else if (dbg_gnt_c) begin
      mem_wr      = dbg_we;
      mem_rd      = ~dbg_we;
      mem_addr    = dbg_addr;
      mem_wr_data = dbg_wdata;
      if (!dbg_we) owner_n = OWN_DBG;
    end
  end

  assign core_stall  = core_req & ~core_gnt;
  assign dbg_gnt     = dbg_gnt_c;
  assign core_rvalid = (rsp_owner == OWN_CORE);
  assign dbg_rvalid  = (rsp_owner == OWN_DBG);
  assign core_rdata  = core_rvalid ? mem_rd_data : core_rdata_q;
  assign dbg_rdata   = dbg_rvalid  ? mem_rd_data : dbg_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port memory.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_wr, mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [512];
  logic        preload;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.DATA_W(32), .ADDR_W(9), .MAX_WAIT(4), .LOCK_MAX(8)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  function automatic logic [31:0] exp_word(input logic [8:0] a);
    return (a == 9'h010) ? 32'hDEADBEEF : (32'h5A5A0000 | {23'b0, a});
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= exp_word(9'(i));
      mem_rd_data <= '0;
    end else begin
      if (mem_wr) mem[mem_addr] <= mem_wr_data;
      if (mem_rd) mem_rd_data <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1; preload = 1;
    idle();
    core_req = 1; dbg_req = 1;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
        bad++; $display("FAIL reset_strobes: rd=%b wr=%b want 0 0", mem_rd, mem_wr);
      end
      total++;
      if (dbg_gnt !== 1'b0) begin bad++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
      total++;
      if (core_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin
        bad++; $display("FAIL reset_rvalid: core=%b dbg=%b want 0 0", core_rvalid, dbg_rvalid);
      end
    end
    tick();
    idle();
    preload = 0;
    reset = 0;
    tick();
  endtask

  task automatic test_core_load();
    core_req = 1; core_we = 0; core_addr = 9'h010;
    @(negedge clk);
    total++;
    if (mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 9'h010) begin
      bad++; $display("FAIL core_load_cmd: rd=%b wr=%b addr=%h want 1 0 010", mem_rd, mem_wr, mem_addr);
    end
    total++;
    if (core_stall !== 1'b0) begin bad++; $display("FAIL core_load_stall0: got %b want 0", core_stall); end
    tick();
    core_req = 0;
    @(negedge clk);
    total++;
    if (core_rvalid !== 1'b1 || core_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL core_load_data: rvalid=%b rdata=%h want 1 deadbeef", core_rvalid, core_rdata);
    end
    total++;
    if (dbg_rvalid !== 1'b0 || core_stall !== 1'b0) begin
      bad++; $display("FAIL core_load_side: dbg_rvalid=%b stall=%b want 0 0", dbg_rvalid, core_stall);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    core_req = 1; core_we = 0; core_addr = 9'h020;
    @(negedge clk);
    #2 reset = 1;
    #1;
    total++;
    if (mem_rd !== 1'b0) begin bad++; $display("FAIL midrst_mem_rd: got %b want 0", mem_rd); end
    tick();
    total++;
    if (core_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_pending: rvalid=%b want 0", core_rvalid); end
    reset = 0;
    @(negedge clk);
    total++;
    if (core_stall !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 9'h020) begin
      bad++; $display("FAIL midrst_arb: stall=%b rd=%b addr=%h want 0 1 020", core_stall, mem_rd, mem_addr);
    end
    tick();
    core_req = 0;
    total++;
    if (core_rvalid !== 1'b1) begin bad++; $display("FAIL midrst_rvalid_up: got %b want 1", core_rvalid); end
    #1 reset = 1;
    #1;
    total++;
    if (core_rvalid !== 1'b0) begin bad++; $display("FAIL midrst_rvalid_drop: got %b want 0", core_rvalid); end
    @(negedge clk);
    reset = 0;
    tick();
  endtask

  task automatic test_starvation();
    core_req = 1; core_we = 0; core_addr = 9'h001;
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h004; dbg_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (dbg_gnt !== (c == 4)) begin bad++; $display("FAIL starve_gnt c%0d: got %b want %b", c, dbg_gnt, c == 4); end
      total++;
      if (core_stall !== (c == 4)) begin bad++; $display("FAIL starve_stall c%0d: got %b want %b", c, core_stall, c == 4); end
      if (c == 4) begin
        total++;
        if (mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 9'h004 || mem_wr_data !== 32'h12345678) begin
          bad++; $display("FAIL starve_write: wr=%b rd=%b addr=%h data=%h want 1 0 004 12345678",
                          mem_wr, mem_rd, mem_addr, mem_wr_data);
        end
      end
      tick();
    end
    dbg_req = 0;
    total++;
    if (mem[4] !== 32'h12345678) begin bad++; $display("FAIL starve_mem: got %h want 12345678", mem[4]); end
    @(negedge clk);
    total++;
    if (core_rvalid !== 1'b0 || dbg_rvalid !== 1'b0 || core_stall !== 1'b0) begin
      bad++; $display("FAIL starve_after: crv=%b drv=%b stall=%b want 0 0 0", core_rvalid, dbg_rvalid, core_stall);
    end
    tick();
    core_req = 0;
    tick();
  endtask

  task automatic test_lock_burst();
    logic       exp_dg, exp_cg, prev_dg, prev_cg, exp_rd;
    logic [8:0] prev_daddr;
    int         k;
    prev_dg = 0; prev_cg = 0; prev_daddr = '0; k = 0;
    core_req = 1; core_we = 0; core_addr = 9'h010;
    dbg_req = 1; dbg_we = 0; dbg_lock = 1; dbg_addr = 9'h100;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      exp_dg = (c >= 4 && c <= 11) || c == 16 || c == 17;
      exp_cg = c < 4 || (c >= 12 && c <= 15) || c >= 19;
      exp_rd = exp_dg | exp_cg;
      total++;
      if (dbg_gnt !== exp_dg) begin bad++; $display("FAIL lock_gnt c%0d: got %b want %b", c, dbg_gnt, exp_dg); end
      total++;
      if (core_stall !== !exp_cg) begin bad++; $display("FAIL lock_stall c%0d: got %b want %b", c, core_stall, !exp_cg); end
      total++;
      if (mem_rd !== exp_rd || mem_wr !== 1'b0) begin
        bad++; $display("FAIL lock_strobe c%0d: rd=%b wr=%b want %b 0", c, mem_rd, mem_wr, exp_rd);
      end
      total++;
      if (dbg_rvalid !== prev_dg || core_rvalid !== prev_cg) begin
        bad++; $display("FAIL lock_rvalid c%0d: drv=%b crv=%b want %b %b", c, dbg_rvalid, core_rvalid, prev_dg, prev_cg);
      end
      if (prev_dg) begin
        total++;
        if (dbg_rdata !== exp_word(prev_daddr)) begin
          bad++; $display("FAIL lock_rdata c%0d: got %h want %h", c, dbg_rdata, exp_word(prev_daddr));
        end
      end
      if (prev_cg) begin
        total++;
        if (core_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL lock_core_rdata c%0d: got %h want deadbeef", c, core_rdata); end
      end
      prev_dg = exp_dg;
      prev_cg = exp_cg;
      if (exp_dg) begin
        prev_daddr = dbg_addr;
        k++;
      end
      tick();
      dbg_addr = 9'(9'h100 + k);
      if (k == 10) dbg_req = 0;
    end
    idle();
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    core_req = 1; core_we = 0; core_addr = 9'h011;
    dbg_req = 1; dbg_we = 0; dbg_addr = 9'h012;
    @(negedge clk);
    total++;
    if (core_stall !== 1'b0 || dbg_gnt !== 1'b0 || mem_addr !== 9'h011) begin
      bad++; $display("FAIL simul_gnt: stall=%b dbg_gnt=%b addr=%h want 0 0 011", core_stall, dbg_gnt, mem_addr);
    end
    tick();
    core_req = 0; dbg_req = 0;
    total++;
    if (dut.wait_cnt !== 3'd1) begin bad++; $display("FAIL simul_wait: got %0d want 1", dut.wait_cnt); end
    total++;
    if (core_rvalid !== 1'b1 || core_rdata !== exp_word(9'h011)) begin
      bad++; $display("FAIL simul_rdata: rvalid=%b rdata=%h want 1 %h", core_rvalid, core_rdata, exp_word(9'h011));
    end
    tick();
    total++;
    if (dut.wait_cnt !== 3'd0) begin bad++; $display("FAIL simul_wait_clr: got %0d want 0", dut.wait_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [8:0]  a;
    logic [31:0] last_dbg, last_core;
    logic        pc, pd;
    last_dbg = dbg_rdata; last_core = core_rdata;
    pc = 0; pd = 0; a = '0;
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c < 8) begin
        if (c % 2 == 0) begin core_req = 1; core_addr = 9'(9'h020 + c); end
        else begin dbg_req = 1; dbg_addr = 9'(9'h030 + c); end
      end
      @(negedge clk);
      total++;
      if (core_stall !== 1'b0 || dbg_gnt !== (c < 8 && c % 2 == 1)) begin
        bad++; $display("FAIL b2b_gnt c%0d: stall=%b dbg_gnt=%b want 0 %b", c, core_stall, dbg_gnt, c < 8 && c % 2 == 1);
      end
      total++;
      if (core_rvalid !== pc || dbg_rvalid !== pd) begin
        bad++; $display("FAIL b2b_rvalid c%0d: crv=%b drv=%b want %b %b", c, core_rvalid, dbg_rvalid, pc, pd);
      end
      if (pc) begin
        total++;
        if (core_rdata !== exp_word(a) || dbg_rdata !== last_dbg) begin
          bad++; $display("FAIL b2b_core c%0d: crd=%h drd=%h want %h %h", c, core_rdata, dbg_rdata, exp_word(a), last_dbg);
        end
        last_core = exp_word(a);
      end
      if (pd) begin
        total++;
        if (dbg_rdata !== exp_word(a) || core_rdata !== last_core) begin
          bad++; $display("FAIL b2b_dbg c%0d: drd=%h crd=%h want %h %h", c, dbg_rdata, core_rdata, exp_word(a), last_core);
        end
        last_dbg = exp_word(a);
      end
      pc = (c < 8 && c % 2 == 0);
      pd = (c < 8 && c % 2 == 1);
      a  = (c % 2 == 0) ? 9'(9'h020 + c) : 9'(9'h030 + c);
      tick();
    end
    idle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    reset = 1;
    preload = 1;
    idle();
    test_reset();
    test_core_load();
    test_reset_mid_read();
    test_starvation();
    test_lock_burst();
    test_simultaneous();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters.
  - The core load/store path (MEM stage) is one requester.
  - A debug/loader port is the other; it is used for program-image load and register/memory inspection.
- The core has default priority. A wait counter guarantees the debug port is granted within a bounded number of cycles.
- Read data returns one cycle after the command and is steered back to the owner.
- Sits between the core datapath and the data memory. Its mem_* outputs drive the memory and the wr/rd/addr/wr_data/rd_data debug taps.

Parameters:
- DATA_W, 32, data width.
- ADDR_W, 9, memory word address width.
- MAX_WAIT, 4, consecutive cycles a pending debug request may be denied before debug is forced.
- LOCK_MAX, 8, maximum consecutive debug grants while dbg_lock is held.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core memory access request
- core_we  in  1  1=store, 0=load
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core store data
- core_stall  out  1  core request not granted this cycle; core holds its request
- core_rvalid  out  1  core load data valid
- core_rdata  out  DATA_W  core load data
- dbg_req  in  1  debug request
- dbg_we  in  1  debug write
- dbg_lock  in  1  request consecutive debug grants (burst)
- dbg_addr  in  ADDR_W  debug address
- dbg_wdata  in  DATA_W  debug write data
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid  out  1  debug read data valid
- dbg_rdata  out  DATA_W  debug read data
- mem_wr  out  1  memory write strobe
- mem_rd  out  1  memory read strobe
- mem_addr  out  ADDR_W  memory address
- mem_wr_data  out  DATA_W  memory write data
- mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_rd

Behaviour:

Clocking and reset:
- One clock. Reset is asynchronous and active-high.
- Reset clears state to ARB, wait_cnt=0, lock_cnt=0, rsp_owner=NONE, core_rvalid=0, dbg_rvalid=0.
- While reset is asserted, all grants and mem strobes are 0.

Grant and command timing:
- Grant is combinational from the current state and the requests. The memory command is issued in the same cycle as the grant.
- At most one grant per cycle. mem_wr and mem_rd are never both 1.
- Handshake: a requester holds req/we/addr/wdata stable until granted.
  - Core is granted iff core_req and core_stall=0.
  - Debug is granted iff dbg_gnt=1.
  - A deasserted request is never granted.
- Mux to memory:
  - Granted core: mem_addr=core_addr, mem_wr_data=core_wdata, mem_wr=core_we, mem_rd=~core_we.
  - Granted debug: the same mapping using dbg_* signals.
  - No grant: both strobes 0, and addr/data are don't-care (drive 0).

Read return:
- Any granted read records rsp_owner in a register.
- Next cycle: the owner's rvalid=1 and its rdata=mem_rd_data.
- The other rvalid stays 0. Its rdata holds its last value.

FSM:
- ARB:
  - Core wins if core_req; otherwise debug wins if dbg_req.
  - wait_cnt increments each cycle dbg_req=1 and is denied. It resets to 0 on a debug grant or when dbg_req=0.
  - When wait_cnt reaches MAX_WAIT, go to DBG_FORCE.
  - A debug grant with dbg_lock=1 goes to DBG_LOCK with lock_cnt=1.
- DBG_FORCE:
  - Debug is granted unconditionally if dbg_req. Core stalls.
  - Next state is ARB, or DBG_LOCK if dbg_lock=1. wait_cnt=0.
  - If dbg_req dropped, return to ARB without a grant.
- DBG_LOCK:
  - Debug is granted each cycle dbg_req&dbg_lock. Core stalls. lock_cnt increments.
  - Exit to ARB when dbg_lock=0, when dbg_req=0, or after the grant that makes lock_cnt=LOCK_MAX.
  - The exit is taken so that the core is granted in the next cycle if core_req. wait_cnt=0 on exit.

Boundaries:
- core_stall = core_req & ~core_grant. It is 0 when core_req=0.
- A debug grant is not counted as waiting.
- Core read followed immediately by debug read: core_rvalid and dbg_rvalid assert on consecutive cycles, never simultaneously.
- Asynchronous reset mid-read drops the pending rvalid.
- wait_cnt saturates at MAX_WAIT.

Test Plan:
- Reset asserted asynchronously mid-cycle with core read pending -> core_rvalid=0 next edge, state ARB, mem_rd=0.
- Core load addr 9'h010 (mem holds 32'hDEADBEEF), dbg idle -> mem_rd=1 addr 0x010 in cycle 0; core_rvalid=1, core_rdata=32'hDEADBEEF in cycle 1; core_stall=0 throughout.
- Core_req held continuously, dbg write 32'h12345678 to 9'h004 -> dbg denied for exactly 4 cycles, granted in cycle 4 with mem_wr=1 addr 0x004; core_stall=1 only in cycle 4.
- dbg_lock=1 with 10 debug reads, core_req continuous -> after the forced grant, exactly 8 consecutive debug grants total; core granted in the next cycle; dbg_rvalid pulses trail each grant by 1.
- Both idle then simultaneous core_req and dbg_req with wait_cnt=0 -> core granted, dbg_gnt=0, wait_cnt=1.
- Alternating core read / debug read, back-to-back -> rvalids alternate, each rdata matches its own address contents, never both high.
